// File: rtl/dma_copy_master_pkg.sv
// ---------------------------------------------------------------------------
// dma_copy_master_pkg
//   Shared definitions for the word-copy DMA master: default geometry of the
//   memory it drives and the copy FSM state encoding.
// ---------------------------------------------------------------------------
package dma_copy_master_pkg;

    localparam int DMA_DATA_W    = 32;  // memory word width
    localparam int DMA_ADDR_W    = 7;   // word-address width
    localparam int DMA_LEN_W     = 7;   // transfer-length width
    localparam int DMA_MEM_DEPTH = 65;  // addressable words 0..DEPTH-1

    // Two cycles per read (address, data) and two per write (setup, commit).
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        DONE = 3'd5
    } dma_state_t;

endpackage

// File: rtl/dma_copy_master_if.sv
// ---------------------------------------------------------------------------
// dma_copy_master_if
//   Single-port word memory bus between the DMA master and the RAM.
//   master : drives en_r / en_w / address / DataIn, receives DataOut
//   slave  : the memory side of the same signals
//   DataOut is valid from the falling edge after the memory latches the
//   read address.
// ---------------------------------------------------------------------------
interface dma_copy_master_if
    import dma_copy_master_pkg::*;
#(
    parameter int DATA_W = DMA_DATA_W,
    parameter int ADDR_W = DMA_ADDR_W
);

    logic              en_r;
    logic              en_w;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;

    modport master (
        output en_r,
        output en_w,
        output address,
        output DataIn,
        input  DataOut
    );

    modport slave (
        input  en_r,
        input  en_w,
        input  address,
        input  DataIn,
        output DataOut
    );

endinterface

// File: rtl/dma_copy_master_req_check.sv
// ---------------------------------------------------------------------------
// dma_req_check
//   Combinational validation of a copy request.
//   Inputs : src_addr, dst_addr (first words), length (word count)
//   Output : req_ok = 1 when length is non-zero and both the source and the
//            destination ranges end at or below MEM_DEPTH.
// ---------------------------------------------------------------------------
module dma_req_check
    import dma_copy_master_pkg::*;
#(
    parameter int ADDR_W    = DMA_ADDR_W,
    parameter int LEN_W     = DMA_LEN_W,
    parameter int MEM_DEPTH = DMA_MEM_DEPTH
) (
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              req_ok
);

    // One bit wider than the widest operand so address+length cannot wrap
    // back into the legal range (ADDR_W+1 bits with the default geometry).
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam logic [SUM_W-1:0] DEPTH = SUM_W'(MEM_DEPTH);

    logic [SUM_W-1:0] src_end;
    logic [SUM_W-1:0] dst_end;

    always_comb begin
        src_end = SUM_W'(src_addr) + SUM_W'(length);
        dst_end = SUM_W'(dst_addr) + SUM_W'(length);
        req_ok  = (length != '0) && (src_end <= DEPTH) && (dst_end <= DEPTH);
    end

endmodule

// File: rtl/dma_copy_master.sv
// ---------------------------------------------------------------------------
// dma_copy_master
//   Copies `length` words from src_addr.. to dst_addr.. in ascending order,
//   one word every four cycles (RD_A, RD_B, WR_A, WR_B), then spends one
//   cycle in DONE. Every output is a register.
//
//   clock, rst_n  : single clock, asynchronous active-low reset
//   start         : request a copy (sampled only in IDLE)
//   abort         : cancel the copy in progress (ignored in IDLE)
//   src_addr, dst_addr, length : request parameters, latched on acceptance
//   busy          : high from the first RD_A through DONE inclusive
//   done          : one-cycle pulse on successful completion
//   error         : one-cycle pulse on a rejected request
//   mem           : memory bus (master side)
// ---------------------------------------------------------------------------
module dma_copy_master
    import dma_copy_master_pkg::*;
#(
    parameter int DATA_W    = DMA_DATA_W,
    parameter int ADDR_W    = DMA_ADDR_W,
    parameter int MEM_DEPTH = DMA_MEM_DEPTH,
    parameter int LEN_W     = DMA_LEN_W
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    dma_copy_master_if.master mem
);

    dma_state_t state, next_state;

    // Latched request and progress.
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  idx_inc;
    logic [DATA_W-1:0] data_q, data_d;

    // Output registers and their next values.
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              en_r_q, en_r_d;
    logic              en_w_q, en_w_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic req_ok;
    logic accept;

    dma_req_check #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_req_check (
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .req_ok   (req_ok)
    );

    assign accept  = (state == IDLE) && start && req_ok;
    assign idx_inc = idx_q + LEN_W'(1);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RD_A;
            RD_A:    next_state = RD_B;
            RD_B:    next_state = WR_A;
            WR_A:    next_state = WR_B;
            WR_B:    next_state = (idx_inc == len_q) ? DONE : RD_A;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // Abort overrides the normal sequence from any active state.
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath next values: request latch, word index, read data capture
    // -----------------------------------------------------------------------
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        len_d  = len_q;
        idx_d  = idx_q;
        data_d = data_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    len_d = length;
                end
            end
            // Read data has been valid since the falling edge inside RD_B.
            RD_B:    data_d = mem.DataOut;
            WR_B:    idx_d  = idx_inc;
            default: ;
        endcase
        // Completion, abort and idling all restart the index at zero.
        if (next_state == IDLE) begin
            idx_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Output decode from the state being entered, so the registered outputs
    // line up with the state register.
    // -----------------------------------------------------------------------
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        en_r_d  = 1'b0;
        en_w_d  = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        case (next_state)
            // The range check guarantees base+idx stays below MEM_DEPTH, so
            // the memory address itself never needs the extra carry bit.
            RD_A, RD_B: begin
                busy_d = 1'b1;
                en_r_d = 1'b1;
                addr_d = src_d + ADDR_W'(idx_d);
            end
            WR_A, WR_B: begin
                busy_d  = 1'b1;
                en_w_d  = 1'b1;
                addr_d  = dst_d + ADDR_W'(idx_d);
                wdata_d = data_d;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
        error_d = (state == IDLE) && start && !req_ok;
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            en_r_q  <= 1'b0;
            en_w_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= next_state;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            en_r_q  <= en_r_d;
            en_w_q  <= en_w_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            len_q  <= len_d;
            idx_q  <= idx_d;
            data_q <= data_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign mem.en_r    = en_r_q;
    assign mem.en_w    = en_w_q;
    assign mem.address = addr_q;
    assign mem.DataIn  = wdata_q;

endmodule

// File: tb/tb_dma_copy_master.sv
// ---------------------------------------------------------------------------
// tb_dma_copy_master
//   Drives dma_copy_master against a behavioural RAM and compares the memory
//   image and the busy/done/error behaviour with a word-level copy model.
// ---------------------------------------------------------------------------
module tb_dma_copy_master;
    import dma_copy_master_pkg::*;

    localparam int DATA_W    = DMA_DATA_W;
    localparam int ADDR_W    = DMA_ADDR_W;
    localparam int LEN_W     = DMA_LEN_W;
    localparam int MEM_DEPTH = DMA_MEM_DEPTH;

    logic              clock = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic              error;

    dma_copy_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dma_copy_master #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH),
        .LEN_W     (LEN_W)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .mem      (bus)
    );

    always #5 clock = ~clock;

    // ----------------------------------------------------------------------
    // RAM: latches address/enables on the rising edge, returns read data on
    // the following falling edge. A write commits only when en_w is held for
    // two consecutive cycles (setup cycle, then commit cycle).
    // ----------------------------------------------------------------------
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_en_r_q = 1'b0;
    logic              ram_en_w_q = 1'b0;
    logic [DATA_W-1:0] ram_din_q;
    logic              bd_we;
    int                bd_addr;
    logic [DATA_W-1:0] bd_data;

    always @(posedge clock) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (ram_en_w_q && bus.en_w && (int'(ram_addr_q) < MEM_DEPTH))
            mem[ram_addr_q] <= ram_din_q;
        ram_addr_q <= bus.address;
        ram_en_r_q <= bus.en_r;
        ram_en_w_q <= bus.en_w;
        ram_din_q  <= bus.DataIn;
    end

    always @(negedge clock) begin
        if (ram_en_r_q && (int'(ram_addr_q) < MEM_DEPTH))
            bus.DataOut <= mem[ram_addr_q];
    end

    // Running totals of output activity, sampled mid-cycle.
    int busy_tot = 0, done_tot = 0, err_tot = 0, acc_tot = 0, both_tot = 0;

    always @(negedge clock) begin
        if (busy)                  busy_tot++;
        if (done)                  done_tot++;
        if (error)                 err_tot++;
        if (bus.en_r || bus.en_w)  acc_tot++;
        if (bus.en_r && bus.en_w)  both_tot++;
    end

    assert property (@(posedge clock) disable iff (!rst_n) !(bus.en_r && bus.en_w))
        else $error("FAIL en_exclusive_assert: en_r and en_w both high");

    // ----------------------------------------------------------------------
    // Checking and reference model
    // ----------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] model [0:MEM_DEPTH-1];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Backdoor write through the RAM process; called just after a rising edge.
    task automatic poke(input int a, input logic [DATA_W-1:0] v);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = v;
        @(posedge clock);
        #1;
        bd_we   = 1'b0;
        model[a] = v;
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < MEM_DEPTH; i++)
            if (mem[i] !== model[i]) bad++;
        check({tag, "_mem"}, bad, 0);
    endtask

    // One request. abort_at = cycle (1 = first cycle after start is taken)
    // in which abort is held high; restart_at = cycle in which a second start
    // is presented. 0 disables either.
    task automatic run_copy(input string tag, input int s, input int d, input int l,
                            input int abort_at, input int restart_at);
        int  b0, d0, e0, a0;
        int  words, exp_busy;
        bit  valid;
        valid = (l != 0) && (s + l <= MEM_DEPTH) && (d + l <= MEM_DEPTH);
        b0 = busy_tot; d0 = done_tot; e0 = err_tot; a0 = acc_tot;
        src_addr = ADDR_W'(s);
        dst_addr = ADDR_W'(d);
        length   = LEN_W'(l);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 4 * l + 8; c++) begin
            abort = (c == abort_at);
            if (c == restart_at) begin
                start    = 1'b1;
                src_addr = '0;
                dst_addr = ADDR_W'(45);
                length   = LEN_W'(2);
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            if (c == abort_at) begin
                check({tag, "_busy_after_abort"}, busy, 0);
                check({tag, "_en_after_abort"}, {bus.en_r, bus.en_w}, 0);
            end
        end
        abort = 1'b0;
        start = 1'b0;

        // Forward word-by-word copy; an abort keeps every word whose commit
        // cycle (the 4th of that word) was reached.
        words    = !valid ? 0 : ((abort_at != 0) ? abort_at / 4 : l);
        exp_busy = !valid ? 0 : ((abort_at != 0) ? abort_at : 4 * l + 1);
        for (int k = 0; k < words; k++)
            model[d + k] = model[s + k];

        check({tag, "_busy_cycles"}, busy_tot - b0, exp_busy);
        check({tag, "_done_pulses"}, done_tot - d0, (valid && abort_at == 0) ? 1 : 0);
        check({tag, "_error_pulses"}, err_tot - e0, valid ? 0 : 1);
        if (!valid)
            check({tag, "_no_access"}, acc_tot - a0, 0);
        compare_mem(tag);
    endtask

    // ----------------------------------------------------------------------
    // Stimulus
    // ----------------------------------------------------------------------
    initial begin
        int b0, d0, e0;
        int s, d, l, ab;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        bd_we    = 1'b0;
        bd_addr  = 0;
        bd_data  = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_error", error, 0);
        check("rst_en",    {bus.en_r, bus.en_w}, 0);
        check("rst_addr",  bus.address, 0);
        check("rst_wdata", bus.DataIn, 0);
        rst_n = 1'b1;

        for (int i = 0; i < MEM_DEPTH; i++)
            poke(i, DATA_W'($urandom));

        // Basic four-word copy.
        poke(0, 11); poke(1, 22); poke(2, 33); poke(3, 44);
        run_copy("copy4", 0, 10, 4, 0, 0);
        check("copy4_mem10", mem[10], 11);
        check("copy4_mem13", mem[13], 44);

        // Rejected requests and the exact top-of-memory boundary.
        run_copy("src_overrun", 60, 0, 6, 0, 0);
        run_copy("len_zero", 5, 5, 0, 0, 0);
        run_copy("top_word", 64, 64, 1, 0, 0);
        run_copy("dst_overrun", 0, 62, 4, 0, 0);

        // Overlapping forward copy smears the first word.
        poke(0, 1); poke(1, 2); poke(2, 3);
        run_copy("overlap", 0, 1, 3, 0, 0);
        check("overlap_mem3", mem[3], 1);

        // Abort during WR_A of word 2, then a fresh request.
        run_copy("abort", 30, 20, 4, 11, 0);
        run_copy("after_abort", 30, 40, 2, 0, 0);

        // A second start while busy must be ignored.
        run_copy("busy_start", 10, 30, 3, 0, 5);

        // Reset pulsed during RD_B.
        src_addr = ADDR_W'(2);
        dst_addr = ADDR_W'(50);
        length   = LEN_W'(3);
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("rdb_en_r", bus.en_r, 1);
        check("rdb_addr", bus.address, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_en",   {bus.en_r, bus.en_w}, 0);
        check("midrst_addr", bus.address, 0);
        check("midrst_pulses", {done, error}, 0);
        b0 = busy_tot; d0 = done_tot; e0 = err_tot;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check("postrst_busy",  busy_tot - b0, 0);
        check("postrst_done",  done_tot - d0, 0);
        check("postrst_error", err_tot - e0, 0);
        compare_mem("postrst");

        // Randomised requests, some aborted part way.
        for (int n = 0; n < 25; n++) begin
            s  = int'($urandom_range(0, 70));
            d  = int'($urandom_range(0, 70));
            l  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                             : int'($urandom_range(0, 10));
            ab = 0;
            if ((l != 0) && (s + l <= MEM_DEPTH) && (d + l <= MEM_DEPTH) &&
                ($urandom_range(0, 2) == 0))
                ab = int'($urandom_range(1, 4 * l));
            run_copy("rnd", s, d, l, ab, 0);
        end

        check("en_exclusive", both_tot, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
